// File: rtl/gcd_rr_scheduler.sv
// ============================================================================
// Module   : gcd_rr_scheduler
// Purpose  : Round-robin arbiter sharing one GCD engine among NREQ requesters.
//            Optional macro GCD_ZERO_BYPASS_EN answers zero-operand jobs locally.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module gcd_rr_scheduler #(
    parameter int WIDTH = 5,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    core_start,
    output logic [WIDTH-1:0]        core_a,
    output logic [WIDTH-1:0]        core_b,
    input  logic                    core_done,
    input  logic [WIDTH-1:0]        core_result,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     idx_q;
    logic [WIDTH-1:0]  core_a_q;
    logic [WIDTH-1:0]  core_b_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic              core_start_q;
    logic              busy_q;

    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [NREQ-1:0]   win_oh;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;
    logic [NREQ-1:0]   idx_oh;
    logic [IW-1:0]     ptr_d;
    logic              zero_bypass;

    // Search order starts at ptr and wraps; the first pending port wins.
    always_comb begin : p_arb
        int tgt;
        tgt       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_a     = '0;
        win_b     = '0;
        for (int k = 0; k < NREQ; k++) begin
            tgt = int'(ptr_q) + k;
            if (tgt >= NREQ) begin
                tgt = tgt - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && (j == tgt) && req_valid[j]) begin
                    win_found = 1'b1;
                    win_idx   = IW'(j);
                    win_a     = req_a[j*WIDTH +: WIDTH];
                    win_b     = req_b[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin : p_onehot
        win_oh = '0;
        idx_oh = '0;
        for (int j = 0; j < NREQ; j++) begin
            win_oh[j] = win_found && (win_idx == IW'(j));
            idx_oh[j] = (idx_q == IW'(j));
        end
    end

    assign ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

`ifdef GCD_ZERO_BYPASS_EN
    assign zero_bypass = (win_a == '0) || (win_b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            idx_q        <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            rsp_valid_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        idx_q    <= win_idx;
                        core_a_q <= win_a;
                        core_b_q <= win_b;
                        busy_q   <= 1'b1;
                        if (zero_bypass) begin
                            // A|B is the GCD when at least one operand is zero.
                            state_q     <= S_RESP;
                            rsp_data_q  <= win_a | win_b;
                            rsp_valid_q <= win_oh;
                        end else begin
                            state_q      <= S_ISSUE;
                            core_start_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_q     <= S_RESP;
                        rsp_data_q  <= core_result;
                        rsp_valid_q <= idx_oh;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst so nothing appears accepted while reset is held.
    assign req_ready  = ((state_q == S_IDLE) && !rst) ? win_oh : '0;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign core_start = core_start_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire
